// File: rtl/npc_mem_pkg.sv
// Shared definitions for the NPC memory arbiter.
// Contents: MemOp encodings, access-size codes, FSM state encodings,
// grant-owner encoding and the memop_size decoder.
package npc_mem_pkg;

  // MemOp codes as driven by the LSU
  localparam logic [2:0] MEMOP_B  = 3'b000;
  localparam logic [2:0] MEMOP_H  = 3'b001;
  localparam logic [2:0] MEMOP_W  = 3'b010;
  localparam logic [2:0] MEMOP_BU = 3'b100;
  localparam logic [2:0] MEMOP_HU = 3'b101;

  // Access size codes returned by memop_size
  localparam logic [1:0] SZ_B   = 2'd0;
  localparam logic [1:0] SZ_H   = 2'd1;
  localparam logic [1:0] SZ_W   = 2'd2;
  localparam logic [1:0] SZ_BAD = 2'd3;

  // FSM states
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_REQ  = 2'd1;
  localparam state_t ST_WAIT = 2'd2;
  localparam state_t ST_RESP = 2'd3;

  // Grant owner
  typedef logic owner_t;
  localparam owner_t OWN_IFU = 1'b0;
  localparam owner_t OWN_LSU = 1'b1;

  // Size comes from memop[1:0]; bit 2 (unsigned) is only legal for b/h,
  // so 3'b110 and any code with [1:0]=2'b11 decode as illegal.
  function automatic logic [1:0] memop_size(input logic [2:0] memop);
    logic [1:0] sz;
    sz = memop[1:0];
    if (memop[1:0] == 2'b11 || (memop[2] && memop[1]))
      sz = SZ_BAD;
    return sz;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane alignment for 32-bit memory accesses.
// Inputs : memop (3-bit MemOp), addr_lo (byte offset), wdata (right-aligned
//          store data), rdata (aligned memory word).
// Outputs: wmask (byte lanes), wdata_sh (store data in its lanes),
//          rdata_ext (load data shifted down and extended), misalign
//          (misaligned access or illegal memop).
module mem_lane_align
  import npc_mem_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [2:0]            memop,
  input  logic [1:0]            addr_lo,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic [3:0]            wmask,
  output logic [DATA_WIDTH-1:0] wdata_sh,
  output logic [DATA_WIDTH-1:0] rdata_ext,
  output logic                  misalign
);

  logic [1:0]            size;
  logic [4:0]            shamt;
  logic [DATA_WIDTH-1:0] rdata_sh;
  logic                  b_sgn;
  logic                  h_sgn;

  always_comb begin
    size      = memop_size(memop);
    shamt     = {addr_lo, 3'b000};
    wdata_sh  = wdata << shamt;
    rdata_sh  = rdata >> shamt;
    // memop[2] marks the unsigned variants
    b_sgn     = ~memop[2] & rdata_sh[7];
    h_sgn     = ~memop[2] & rdata_sh[15];
    wmask     = 4'b0000;
    rdata_ext = '0;
    misalign  = 1'b0;
    case (size)
      SZ_B: begin
        wmask     = 4'b0001 << addr_lo;
        rdata_ext = {{(DATA_WIDTH-8){b_sgn}}, rdata_sh[7:0]};
      end
      SZ_H: begin
        wmask     = 4'b0011 << addr_lo;
        rdata_ext = {{(DATA_WIDTH-16){h_sgn}}, rdata_sh[15:0]};
        misalign  = addr_lo[0];
      end
      SZ_W: begin
        wmask     = 4'b1111;
        rdata_ext = rdata_sh;
        misalign  = |addr_lo;
      end
      default: misalign = 1'b1;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter/sequencer (IFU + LSU -> one memory port).
// Round-robin arbitration, one outstanding transaction, IDLE/REQ/WAIT/RESP
// sequencing. LSU accesses are lane-aligned and loads are extended via
// mem_lane_align; misaligned/illegal LSU requests answer with an error
// without touching memory.
// Ports: clk, rst_n (sync, active-low); ifu_req_*/ifu_resp_* and
// lsu_req_*/lsu_resp_* valid/ready handshakes with their payloads;
// mem_req_*/mem_* memory request side; mem_resp_valid/mem_rdata response.
module mem_arbiter
  import npc_mem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ifu_req_valid,
  output logic                  ifu_req_ready,
  input  logic [ADDR_WIDTH-1:0] ifu_addr,
  output logic                  ifu_resp_valid,
  input  logic                  ifu_resp_ready,
  output logic [DATA_WIDTH-1:0] ifu_rdata,
  input  logic                  lsu_req_valid,
  output logic                  lsu_req_ready,
  input  logic [ADDR_WIDTH-1:0] lsu_addr,
  input  logic [2:0]            lsu_memop,
  input  logic                  lsu_wen,
  input  logic [DATA_WIDTH-1:0] lsu_wdata,
  output logic                  lsu_resp_valid,
  input  logic                  lsu_resp_ready,
  output logic [DATA_WIDTH-1:0] lsu_rdata,
  output logic                  lsu_resp_err,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_wen,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [3:0]            mem_wmask,
  input  logic                  mem_resp_valid,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_LO_MASK = ADDR_WIDTH'(3);

  state_t                state_q, state_d;
  owner_t                last_grant_q, last_grant_d;
  owner_t                owner_q, owner_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [1:0]            addr_lo_q, addr_lo_d;
  logic [2:0]            memop_q, memop_d;
  logic                  wen_q, wen_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [3:0]            wmask_q, wmask_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;

  logic                  grant_ifu, grant_lsu;
  logic [2:0]            al_memop;
  logic [1:0]            al_addr_lo;
  logic [3:0]            al_wmask;
  logic [DATA_WIDTH-1:0] al_wdata;
  logic [DATA_WIDTH-1:0] al_rdata;
  logic                  al_misalign;
  logic                  resp_done;

  // One aligner serves both phases: live LSU fields while arbitrating in
  // IDLE, latched fields while the response is being extended in WAIT.
  assign al_memop   = (state_q == ST_IDLE) ? lsu_memop : memop_q;
  assign al_addr_lo = (state_q == ST_IDLE) ? lsu_addr[1:0] : addr_lo_q;

  mem_lane_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
    .memop    (al_memop),
    .addr_lo  (al_addr_lo),
    .wdata    (lsu_wdata),
    .rdata    (mem_rdata),
    .wmask    (al_wmask),
    .wdata_sh (al_wdata),
    .rdata_ext(al_rdata),
    .misalign (al_misalign)
  );

  // Round-robin: on a tie the requester not granted last time wins.
  always_comb begin
    grant_ifu = 1'b0;
    grant_lsu = 1'b0;
    if (rst_n && state_q == ST_IDLE) begin
      if (ifu_req_valid && lsu_req_valid) begin
        grant_ifu = (last_grant_q == OWN_LSU);
        grant_lsu = (last_grant_q == OWN_IFU);
      end else begin
        grant_ifu = ifu_req_valid;
        grant_lsu = lsu_req_valid;
      end
    end
  end

  assign resp_done = (owner_q == OWN_IFU) ? ifu_resp_ready : lsu_resp_ready;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    addr_d       = addr_q;
    addr_lo_d    = addr_lo_q;
    memop_d      = memop_q;
    wen_d        = wen_q;
    wdata_d      = wdata_q;
    wmask_d      = wmask_q;
    rdata_d      = rdata_q;
    err_d        = err_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_ifu) begin
          // Fetches are always aligned word reads; low address bits dropped
          state_d      = ST_REQ;
          last_grant_d = OWN_IFU;
          owner_d      = OWN_IFU;
          addr_d       = ifu_addr & ~ADDR_LO_MASK;
          addr_lo_d    = 2'b00;
          memop_d      = MEMOP_W;
          wen_d        = 1'b0;
          wdata_d      = '0;
          wmask_d      = 4'b1111;
          rdata_d      = '0;
          err_d        = 1'b0;
        end else if (grant_lsu) begin
          // Misaligned/illegal requests skip memory and answer directly
          state_d      = al_misalign ? ST_RESP : ST_REQ;
          last_grant_d = OWN_LSU;
          owner_d      = OWN_LSU;
          addr_d       = lsu_addr & ~ADDR_LO_MASK;
          addr_lo_d    = lsu_addr[1:0];
          memop_d      = lsu_memop;
          wen_d        = lsu_wen;
          wdata_d      = al_wdata;
          wmask_d      = al_wmask;
          rdata_d      = '0;
          err_d        = al_misalign;
        end
      end
      ST_REQ: begin
        if (mem_req_ready) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (mem_resp_valid) begin
          state_d = ST_RESP;
          rdata_d = wen_q ? '0 : al_rdata;
        end
      end
      ST_RESP: begin
        if (resp_done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      last_grant_q <= OWN_LSU;
      owner_q      <= OWN_IFU;
      addr_q       <= '0;
      addr_lo_q    <= '0;
      memop_q      <= '0;
      wen_q        <= 1'b0;
      wdata_q      <= '0;
      wmask_q      <= '0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      addr_q       <= addr_d;
      addr_lo_q    <= addr_lo_d;
      memop_q      <= memop_d;
      wen_q        <= wen_d;
      wdata_q      <= wdata_d;
      wmask_q      <= wmask_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
    end
  end

  assign ifu_req_ready  = grant_ifu;
  assign lsu_req_ready  = grant_lsu;
  assign mem_req_valid  = (state_q == ST_REQ);
  assign mem_addr       = addr_q;
  assign mem_wen        = wen_q;
  assign mem_wdata      = wdata_q;
  assign mem_wmask      = wmask_q;
  assign ifu_resp_valid = (state_q == ST_RESP) && (owner_q == OWN_IFU);
  assign lsu_resp_valid = (state_q == ST_RESP) && (owner_q == OWN_LSU);
  assign ifu_rdata      = (owner_q == OWN_IFU) ? rdata_q : '0;
  assign lsu_rdata      = (owner_q == OWN_LSU) ? rdata_q : '0;
  assign lsu_resp_err   = lsu_resp_valid & err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ifu_req_valid = 1'b0;
  logic        ifu_req_ready;
  logic [31:0] ifu_addr = '0;
  logic        ifu_resp_valid;
  logic        ifu_resp_ready = 1'b0;
  logic [31:0] ifu_rdata;
  logic        lsu_req_valid = 1'b0;
  logic        lsu_req_ready;
  logic [31:0] lsu_addr = '0;
  logic [2:0]  lsu_memop = '0;
  logic        lsu_wen = 1'b0;
  logic [31:0] lsu_wdata = '0;
  logic        lsu_resp_valid;
  logic        lsu_resp_ready = 1'b0;
  logic [31:0] lsu_rdata;
  logic        lsu_resp_err;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic [31:0] mem_addr;
  logic        mem_wen;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_resp_valid = 1'b0;
  logic [31:0] mem_rdata = '0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_resp_ready(ifu_resp_ready), .ifu_rdata(ifu_rdata),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
    .lsu_memop(lsu_memop), .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata),
    .lsu_resp_valid(lsu_resp_valid), .lsu_resp_ready(lsu_resp_ready), .lsu_rdata(lsu_rdata),
    .lsu_resp_err(lsu_resp_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ifu_accept(input logic [31:0] a, output bit ok, output int tries);
    ifu_req_valid = 1'b1; ifu_addr = a; ok = 0; tries = 0;
    while (!ok && tries < 10) begin
      #1; tries++;
      if (ifu_req_ready) ok = 1;
      step();
    end
    ifu_req_valid = 1'b0;
  endtask

  task automatic lsu_accept(input logic [31:0] a, input logic [2:0] op, input logic w,
                            input logic [31:0] wd, output bit ok, output int tries);
    lsu_req_valid = 1'b1; lsu_addr = a; lsu_memop = op; lsu_wen = w; lsu_wdata = wd;
    ok = 0; tries = 0;
    while (!ok && tries < 10) begin
      #1; tries++;
      if (lsu_req_ready) ok = 1;
      step();
    end
    lsu_req_valid = 1'b0;
  endtask

  // Minimum-latency memory responder plus master response capture. Entered
  // one cycle after acceptance; lat counts cycles from acceptance.
  task automatic serve(input bit is_ifu, input logic [31:0] mrd,
                       output logic [31:0] rdata, output logic err, output bit saw_mem,
                       output int lat, output logic [31:0] m_addr, output logic [31:0] m_wdata,
                       output logic [3:0] m_wmask, output logic m_wen);
    bit pend = 0;
    bit done = 0;
    int cyc = 1;
    rdata = '0; err = 1'b0; saw_mem = 0; lat = -1;
    m_addr = '0; m_wdata = '0; m_wmask = '0; m_wen = 1'b0;
    while (!done && cyc <= 20) begin
      mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
      if (mem_req_valid) begin
        saw_mem = 1; m_addr = mem_addr; m_wdata = mem_wdata; m_wmask = mem_wmask; m_wen = mem_wen;
        mem_req_ready = 1'b1; pend = 1;
      end else if (pend) begin
        mem_resp_valid = 1'b1; mem_rdata = mrd; pend = 0;
      end
      if (is_ifu ? ifu_resp_valid : lsu_resp_valid) begin
        rdata = is_ifu ? ifu_rdata : lsu_rdata;
        err = lsu_resp_err; lat = cyc; done = 1;
        if (is_ifu) ifu_resp_ready = 1'b1; else lsu_resp_ready = 1'b1;
      end
      step(); cyc++;
    end
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; ifu_resp_ready = 1'b0; lsu_resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] ctl;
    rst_n = 1'b0; ifu_req_valid = 1'b1; lsu_req_valid = 1'b1;
    step(); step();
    ctl = {25'd0, ifu_req_ready, lsu_req_ready, mem_req_valid, ifu_resp_valid,
           lsu_resp_valid, lsu_resp_err, mem_wen};
    n_tests++;
    if (ctl !== 32'd0) begin n_fail++; $display("FAIL reset_ctl: got %h expected %h", ctl, 32'd0); end
    n_tests++;
    if ({mem_addr, mem_wdata, mem_wmask} !== 68'd0) begin
      n_fail++; $display("FAIL reset_mem_data: got %h/%h/%h expected 0", mem_addr, mem_wdata, mem_wmask);
    end
    n_tests++;
    if ({ifu_rdata, lsu_rdata} !== 64'd0) begin
      n_fail++; $display("FAIL reset_rdata: got %h/%h expected 0", ifu_rdata, lsu_rdata);
    end
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_ifu_read();
    bit ok, saw; int tries, lat; logic [31:0] r, ma, mw; logic e, mwen; logic [3:0] mm;
    ifu_accept(32'h8000_0000, ok, tries);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL ifu_accept: got %0d expected 1", ok); end
    serve(1'b1, 32'h1234_5678, r, e, saw, lat, ma, mw, mm, mwen);
    n_tests++;
    if (r !== 32'h1234_5678) begin n_fail++; $display("FAIL ifu_rdata: got %h expected %h", r, 32'h1234_5678); end
    n_tests++;
    if (lat != 3) begin n_fail++; $display("FAIL ifu_latency: got %0d expected 3", lat); end
    n_tests++;
    if ({saw, ma, mwen} !== {1'b1, 32'h8000_0000, 1'b0}) begin
      n_fail++; $display("FAIL ifu_mem_req: got saw=%0d addr=%h wen=%0d expected 1/80000000/0", saw, ma, mwen);
    end
  endtask

  task automatic test_arbitration();
    bit saw; int lat; logic [31:0] r, ma, mw; logic e, mwen; logic [3:0] mm;
    logic [31:0] exp_r [3] = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333};
    bit          exp_i [3] = '{1'b1, 1'b0, 1'b1};
    rst_n = 1'b0;
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0100;
    lsu_req_valid = 1'b1; lsu_addr = 32'h8000_0200; lsu_memop = 3'b010; lsu_wen = 1'b0;
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_tests++;
      if ({ifu_req_ready, lsu_req_ready} !== {exp_i[k], ~exp_i[k]}) begin
        n_fail++; $display("FAIL tie_grant[%0d]: got ifu=%0d lsu=%0d expected ifu=%0d", k,
                           ifu_req_ready, lsu_req_ready, exp_i[k]);
      end
      step();
      serve(exp_i[k], exp_r[k], r, e, saw, lat, ma, mw, mm, mwen);
      n_tests++;
      if (r !== exp_r[k] || lat != 3) begin
        n_fail++; $display("FAIL tie_xact[%0d]: got %h lat %0d expected %h lat 3", k, r, lat, exp_r[k]);
      end
    end
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
    step();
  endtask

  task automatic test_load_ext();
    bit ok, saw; int tries, lat; logic [31:0] r, ma, mw; logic e, mwen; logic [3:0] mm;
    logic [31:0] va [6] = '{32'h8000_0003, 32'h8000_0003, 32'h8000_0002,
                            32'h8000_0002, 32'h8000_0000, 32'h8000_0001};
    logic [2:0]  vo [6] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b000};
    logic [31:0] vm [6] = '{32'h80FF_FFFF, 32'h80FF_FFFF, 32'h80FF_FFFF,
                            32'h80FF_FFFF, 32'hCAFE_F00D, 32'h0000_7F00};
    logic [31:0] ve [6] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF,
                            32'h0000_80FF, 32'hCAFE_F00D, 32'h0000_007F};
    logic [3:0]  vk [6] = '{4'b1000, 4'b1000, 4'b1100, 4'b1100, 4'b1111, 4'b0010};
    for (int i = 0; i < 6; i++) begin
      lsu_accept(va[i], vo[i], 1'b0, 32'h0, ok, tries);
      serve(1'b0, vm[i], r, e, saw, lat, ma, mw, mm, mwen);
      n_tests++;
      if (r !== ve[i] || e !== 1'b0 || lat != 3) begin
        n_fail++; $display("FAIL load_ext[%0d]: got %h err %0d lat %0d expected %h err 0 lat 3",
                           i, r, e, lat, ve[i]);
      end
      n_tests++;
      if (mm !== vk[i] || ma !== 32'h8000_0000 || mwen !== 1'b0 || !saw) begin
        n_fail++; $display("FAIL load_req[%0d]: got mask %b addr %h wen %0d expected mask %b addr 80000000 wen 0",
                           i, mm, ma, mwen, vk[i]);
      end
    end
  endtask

  task automatic test_store();
    bit ok, saw; int tries, lat; logic [31:0] r, ma, mw; logic e, mwen; logic [3:0] mm;
    logic [31:0] va [3] = '{32'h8000_0002, 32'h8000_0001, 32'h8000_0004};
    logic [2:0]  vo [3] = '{3'b001, 3'b000, 3'b010};
    logic [31:0] vd [3] = '{32'hAAAA_BEEF, 32'h1234_5678, 32'h0BAD_F00D};
    logic [31:0] ea [3] = '{32'h8000_0000, 32'h8000_0000, 32'h8000_0004};
    logic [31:0] ew [3] = '{32'hBEEF_0000, 32'h3456_7800, 32'h0BAD_F00D};
    logic [3:0]  ek [3] = '{4'b1100, 4'b0010, 4'b1111};
    for (int i = 0; i < 3; i++) begin
      lsu_accept(va[i], vo[i], 1'b1, vd[i], ok, tries);
      serve(1'b0, 32'hDEAD_BEEF, r, e, saw, lat, ma, mw, mm, mwen);
      n_tests++;
      if (ma !== ea[i] || mw !== ew[i] || mm !== ek[i] || mwen !== 1'b1) begin
        n_fail++; $display("FAIL store_req[%0d]: got addr %h wdata %h mask %b wen %0d expected %h %h %b 1",
                           i, ma, mw, mm, mwen, ea[i], ew[i], ek[i]);
      end
      n_tests++;
      if (r !== 32'h0 || e !== 1'b0 || lat != 3) begin
        n_fail++; $display("FAIL store_resp[%0d]: got rdata %h err %0d lat %0d expected 0 0 3", i, r, e, lat);
      end
    end
  endtask

  task automatic test_error();
    bit ok, saw; int tries, lat; logic [31:0] r, ma, mw; logic e, mwen; logic [3:0] mm;
    logic [31:0] va [4] = '{32'h8000_0001, 32'h8000_0000, 32'h8000_0003, 32'h8000_0002};
    logic [2:0]  vo [4] = '{3'b010, 3'b011, 3'b101, 3'b010};
    logic        vw [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      lsu_accept(va[i], vo[i], vw[i], 32'hFFFF_FFFF, ok, tries);
      serve(1'b0, 32'h5555_5555, r, e, saw, lat, ma, mw, mm, mwen);
      n_tests++;
      if (e !== 1'b1 || lat != 1 || saw || r !== 32'h0) begin
        n_fail++; $display("FAIL err_path[%0d]: got err %0d lat %0d mem %0d rdata %h expected 1 1 0 0",
                           i, e, lat, saw, r);
      end
    end
  endtask

  task automatic test_back_to_back();
    bit ok, saw; int tries, lat; logic [31:0] r, ma, mw; logic e, mwen; logic [3:0] mm;
    lsu_accept(32'h8000_0010, 3'b010, 1'b0, 32'h0, ok, tries);
    serve(1'b0, 32'h0102_0304, r, e, saw, lat, ma, mw, mm, mwen);
    lsu_accept(32'h8000_0011, 3'b100, 1'b0, 32'h0, ok, tries);
    n_tests++;
    if (!ok || tries != 1) begin
      n_fail++; $display("FAIL b2b_accept: got ok %0d tries %0d expected 1 1", ok, tries);
    end
    serve(1'b0, 32'h0102_0304, r, e, saw, lat, ma, mw, mm, mwen);
    n_tests++;
    if (r !== 32'h0000_0003 || lat != 3) begin
      n_fail++; $display("FAIL b2b_rdata: got %h lat %0d expected 00000003 lat 3", r, lat);
    end
  endtask

  task automatic test_reset_midflight();
    bit ok, saw; int tries, lat; logic [31:0] r, ma, mw; logic e, mwen; logic [3:0] mm;
    ifu_accept(32'h8000_0040, ok, tries);
    // Stray response while in REQ must be ignored
    mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    step();
    mem_resp_valid = 1'b0;
    n_tests++;
    if (mem_req_valid !== 1'b1 || mem_addr !== 32'h8000_0040 || ifu_resp_valid !== 1'b0) begin
      n_fail++; $display("FAIL req_hold: got valid %0d addr %h resp %0d expected 1 80000040 0",
                         mem_req_valid, mem_addr, ifu_resp_valid);
    end
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    rst_n = 1'b0;
    step();
    n_tests++;
    if ({mem_req_valid, ifu_resp_valid, lsu_resp_valid, ifu_req_ready, lsu_req_ready, mem_wen} !== 6'd0 ||
        {mem_addr, mem_wdata, mem_wmask, ifu_rdata} !== 100'd0) begin
      n_fail++; $display("FAIL wait_reset: got valid %0d addr %h mask %b rdata %h expected all 0",
                         mem_req_valid, mem_addr, mem_wmask, ifu_rdata);
    end
    rst_n = 1'b1;
    mem_resp_valid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    step();
    mem_resp_valid = 1'b0;
    step();
    n_tests++;
    if ({mem_req_valid, ifu_resp_valid, lsu_resp_valid} !== 3'b000) begin
      n_fail++; $display("FAIL stray_resp: got %b expected 000", {mem_req_valid, ifu_resp_valid, lsu_resp_valid});
    end
    ifu_accept(32'h8000_0082, ok, tries);
    serve(1'b1, 32'h0A0B_0C0D, r, e, saw, lat, ma, mw, mm, mwen);
    n_tests++;
    if (r !== 32'h0A0B_0C0D || lat != 3 || ma !== 32'h8000_0080) begin
      n_fail++; $display("FAIL post_reset_ifu: got %h lat %0d addr %h expected 0a0b0c0d 3 80000080", r, lat, ma);
    end
  endtask

  initial begin
    test_reset();
    test_ifu_read();
    test_arbitration();
    test_load_ext();
    test_store();
    test_error();
    test_back_to_back();
    test_reset_midflight();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester memory arbiter/sequencer for the NPC core. It shares one memory port between the instruction fetch unit (IFU) and the load/store unit (LSU) using valid/ready handshakes and round-robin arbitration. It also performs byte-lane alignment, write-mask generation and load sign/zero extension from the 3-bit MemOp code. It sits between IFU/LSU and the DPI-backed memory model.

## Interface
- DATA_WIDTH, 32, data width; only 32 is supported.
- ADDR_WIDTH, 32, address width.

- clk  in  1  sole clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- ifu_req_valid / ifu_req_ready  in / out  1  IFU request handshake.
- ifu_addr  in  ADDR_WIDTH  fetch address; always a 32-bit read.
- ifu_resp_valid / ifu_resp_ready  out / in  1  IFU response handshake.
- ifu_rdata  out  DATA_WIDTH  fetched word.
- lsu_req_valid / lsu_req_ready  in / out  1  LSU request handshake.
- lsu_addr  in  ADDR_WIDTH  byte address.
- lsu_memop  in  3  000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu; other codes are illegal.
- lsu_wen  in  1  store when 1.
- lsu_wdata  in  DATA_WIDTH  store data, right-aligned.
- lsu_resp_valid / lsu_resp_ready  out / in  1  LSU response handshake.
- lsu_rdata  out  DATA_WIDTH  extended load data; 0 for stores and errors.
- lsu_resp_err  out  1  misaligned access or illegal memop.
- mem_req_valid / mem_req_ready  out / in  1  memory request handshake.
- mem_addr  out  ADDR_WIDTH  word-aligned address {addr[31:2],2'b00}.
- mem_wen  out  1  write enable.
- mem_wdata  out  DATA_WIDTH  wdata shifted left by addr[1:0]*8.
- mem_wmask  out  4  byte lanes: b 4'b0001<<a, h 4'b0011<<a, w 4'b1111.
- mem_resp_valid  in  1  read data / write acknowledge; exactly one per accepted request.
- mem_rdata  in  DATA_WIDTH  aligned word.

## Operation
- FSM states:
  - IDLE: select a requester.
  - REQ: drive mem_req_valid.
  - WAIT: await mem_resp_valid.
  - RESP: drive the granted master's resp_valid.
- IDLE behaviour:
  - ifu_req_ready/lsu_req_ready are high combinationally only for the arbitration winner.
  - The handshake latches addr, memop, wen, wdata and the grant owner into request registers.
- Arbitration: single requester wins. On a simultaneous request, the one not granted last wins. last_grant updates on every accepted request.
- IDLE→REQ on an accepted legal request.
- LSU error path: an accepted LSU request that is misaligned goes IDLE→RESP directly, with lsu_resp_err=1, rdata 0, and no memory transaction. Misaligned means lh/lhu with a[0]=1, lw with a[1:0]≠0, or any illegal memop.
- IFU address: IFU addresses are never checked; low bits are dropped.
- REQ→WAIT when mem_req_ready=1. mem_* outputs are held stable while mem_req_valid=1.
- WAIT→RESP on mem_resp_valid; mem_rdata is captured and extended:
  - Shift right by a*8.
  - lb/lh sign-extend from bit 7/15; lbu/lhu zero-extend; lw passes through.
  - Stores return rdata 0.
- RESP→IDLE when the owner's resp_ready=1. resp_valid and rdata are held until then.
- Only one transaction is outstanding; no request is accepted outside IDLE.

## Timing
- Reset values (rst_n low at a clock edge):
  - state IDLE; last_grant = LSU, so IFU wins the first tie.
  - All *_valid, *_ready, err outputs and data outputs are 0.
- Reset during REQ/WAIT/RESP abandons the transaction.
- A mem_resp_valid arriving in IDLE or REQ is ignored.
- Minimum legal latency:
  - Request accepted at cycle T.
  - mem_req_valid at T+1; if mem_req_ready=1, the handshake completes at T+1.
  - mem_resp_valid no earlier than T+2.
  - Master resp_valid at T+3 (registered).
- Error-path latency: accept at T, lsu_resp_valid at T+1.
- Back-to-back: the next request can be accepted in the cycle after the RESP handshake (one IDLE cycle).
- A requester dropping valid before acceptance is legal; nothing is latched.

## Structure
- Package npc_mem_pkg:
  - MemOp localparams (MEMOP_B/H/W/BU/HU).
  - FSM state enum.
  - Grant-owner encoding.
  - Function memop_size decoding MemOp[1:0].
- Sub-module mem_lane_align (combinational):
  - Inputs: memop, addr[1:0], wdata, rdata.
  - Outputs: wmask, shifted wdata, extended rdata, misalign flag.
- mem_arbiter holds the FSM, arbitration and request/response registers.

## Test plan
- Reset, then IFU read 0x8000_0000; memory returns 0x1234_5678 with 1-cycle latency. Expect ifu_rdata=0x1234_5678, ifu_resp_valid at T+3, mem_wmask ignored, mem_wen=0.
- IFU and LSU both request in the first cycle after reset. Expect IFU granted first, LSU second; repeat the tie and expect IFU again (alternation).
- LSU lb at 0x8000_0003 with mem_rdata 0x80FF_FFFF. Expect lsu_rdata 0xFFFF_FF80; lbu gives 0x0000_0080; lh at 0x8000_0002 gives 0xFFFF_80FF.
- LSU sh at 0x8000_0002, wdata 0xAAAA_BEEF. Expect mem_addr 0x8000_0000, mem_wmask 4'b1100, mem_wdata 0xBEEF_xxxx upper half = 0xBEEF, lsu_rdata 0.
- LSU lw at 0x8000_0001 and memop 3'b011. Expect lsu_resp_err=1 at T+1, no mem_req_valid pulse.
- rst_n low during WAIT, then a stray mem_resp_valid. Expect all outputs 0, state IDLE, stray response ignored, next IFU request completes normally.
